// File: rtl/nv_ram_rws_256x128_fifo_if.sv
// Bundle of the producer, consumer and RAM-port signals of the
// 256x128 RAM-backed FIFO controller.
//   slave  : the FIFO controller side
//   master : the environment side (producer, consumer and RAM)
// Ports carried: wr_pvld/wr_prdy/wr_pd, rd_pvld/rd_prdy/rd_pd,
//   ram_we/ram_wa/ram_di, ram_re/ram_ra/ram_dout, fifo_cnt.
interface nv_ram_rws_256x128_fifo_if #(
  parameter int AW = 8,
  parameter int DW = 128
);
  logic          wr_pvld;
  logic          wr_prdy;
  logic [DW-1:0] wr_pd;
  logic          rd_pvld;
  logic          rd_prdy;
  logic [DW-1:0] rd_pd;
  logic          ram_we;
  logic [AW-1:0] ram_wa;
  logic [DW-1:0] ram_di;
  logic          ram_re;
  logic [AW-1:0] ram_ra;
  logic [DW-1:0] ram_dout;
  logic [AW+1:0] fifo_cnt;

  modport slave (
    input  wr_pvld, wr_pd, rd_prdy, ram_dout,
    output wr_prdy, rd_pvld, rd_pd, ram_we, ram_wa, ram_di,
           ram_re, ram_ra, fifo_cnt
  );

  modport master (
    output wr_pvld, wr_pd, rd_prdy, ram_dout,
    input  wr_prdy, rd_pvld, rd_pd, ram_we, ram_wa, ram_di,
           ram_re, ram_ra, fifo_cnt
  );
endinterface

// File: rtl/nv_ram_rws_256x128_fifo.sv
// Valid/ready FIFO controller owning both ports of an external 256x128
// two-port RAM (sync write, registered read address, combinational dout).
// Read data is captured into a 2-entry skid stage so the consumer sees a
// full-rate stream.
// Ports:
//   nvdla_core_clk  : clock, shared with the RAM
//   nvdla_core_rstn : async active-low reset
//   bus (slave)     : write side, read side, RAM ports, fifo_cnt
module nv_ram_rws_256x128_fifo #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 128
) (
  input  logic                        nvdla_core_clk,
  input  logic                        nvdla_core_rstn,
  nv_ram_rws_256x128_fifo_if.slave    bus
);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr, rd_ptr, ra_q;
  logic [AW:0]   ram_cnt, ram_cnt_nxt;
  logic          inflight;
  logic [1:0]    skid_cnt, skid_cnt_nxt, cap_idx;
  logic [DW-1:0] skid0, skid1;
  logic [AW+1:0] cnt_q, cnt_nxt;
  logic [2:0]    credit;
  logic          accept, pop, issue;

  assign bus.wr_prdy = (ram_cnt != FULL);
  assign accept      = bus.wr_pvld & bus.wr_prdy;
  assign pop         = bus.rd_pvld & bus.rd_prdy;

  // Occupancy of the skid stage after this edge if nothing new is issued;
  // an issue now lands in the skid two edges later, so it needs a free slot.
  assign credit = {1'b0, skid_cnt} + {2'b0, inflight} - {2'b0, pop};
  assign issue  = (ram_cnt != '0) && (credit < 3'd2);

  assign bus.ram_we = accept;
  assign bus.ram_wa = wr_ptr;
  assign bus.ram_di = bus.wr_pd;
  assign bus.ram_re = issue;
  assign bus.ram_ra = issue ? rd_ptr : ra_q;

  assign bus.rd_pvld  = (skid_cnt != 2'd0);
  assign bus.rd_pd    = skid0;
  assign bus.fifo_cnt = cnt_q;

  always_comb begin
    ram_cnt_nxt = ram_cnt;
    if (accept && !issue)      ram_cnt_nxt = ram_cnt + (AW+1)'(1);
    else if (!accept && issue) ram_cnt_nxt = ram_cnt - (AW+1)'(1);
  end

  assign skid_cnt_nxt = skid_cnt + {1'b0, inflight} - {1'b0, pop};
  // Slot the captured word goes to, after any pop has shifted the stage.
  assign cap_idx      = skid_cnt - {1'b0, pop};
  assign cnt_nxt      = (AW+2)'(ram_cnt_nxt) + (AW+2)'(issue) + (AW+2)'(skid_cnt_nxt);

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ra_q     <= '0;
      ram_cnt  <= '0;
      inflight <= 1'b0;
      skid_cnt <= 2'd0;
      skid0    <= '0;
      skid1    <= '0;
      cnt_q    <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (issue) begin
        rd_ptr <= rd_ptr + AW'(1);
        ra_q   <= rd_ptr;
      end
      ram_cnt  <= ram_cnt_nxt;
      inflight <= issue;
      skid_cnt <= skid_cnt_nxt;
      cnt_q    <= cnt_nxt;
      if (pop) skid0 <= skid1;
      // Later assignment wins over the shift when the capture targets slot 0.
      if (inflight) begin
        if (cap_idx == 2'd0) skid0 <= bus.ram_dout;
        else                 skid1 <= bus.ram_dout;
      end
    end
  end
endmodule
